// File: rtl/clas_pkg.sv
// Shared opcodes and default geometry for the pipelined carry-lookahead add/sub unit.
package clas_pkg;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 8;
endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder; zero latency, no flow control.
module cla_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout
);
   logic [SLICE-1:0] g;
   logic [SLICE-1:0] p;
   logic [SLICE-1:0] c;
   logic             grp_g;
   logic             grp_p;

   always_comb begin
      g = a & b;
      p = a ^ b;
      c = '0;
      c[0] = cin;
      for (int i = 0; i < SLICE - 1; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      // Group generate/propagate gives the slice carry-out independent of the internal chain.
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < SLICE; i++) begin
         grp_g = g[i] | (p[i] & grp_g);
         grp_p = grp_p & p[i];
      end
      sum  = p ^ c;
      cout = grp_g | (grp_p & cin);
   end
endmodule

// File: rtl/clas_pipe.sv
// Pipelined add/sub, one SLICE per stage; latency STAGES cycles, 1 op/cycle.
// Backpressure: whole pipe freezes when the output is held (in_ready = !out_valid || out_ready).
module clas_pipe
   import clas_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);
   localparam int STAGES = WIDTH / SLICE;

   if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_param
      $error("clas_pipe: WIDTH must be a non-zero multiple of SLICE");
   end

   // Index k holds the state entering slice k; index STAGES is the output register.
   logic             v_q  [0:STAGES];
   logic             v_d  [0:STAGES];
   logic             c_q  [0:STAGES];
   logic             c_d  [0:STAGES];
   logic [WIDTH-1:0] r_q  [0:STAGES];
   logic [WIDTH-1:0] r_d  [0:STAGES];
   logic [WIDTH-1:0] a_q  [0:STAGES-1];
   logic [WIDTH-1:0] a_d  [0:STAGES-1];
   logic [WIDTH-1:0] bp_q [0:STAGES-1];
   logic [WIDTH-1:0] bp_d [0:STAGES-1];
   logic             ovf_q;
   logic             ovf_d;
   logic             zero_q;
   logic             zero_d;

   logic [SLICE-1:0] sum_w [0:STAGES-1];
   logic             co_w  [0:STAGES-1];
   logic [WIDTH-1:0] r_last;
   logic             advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_slice #(.SLICE(SLICE)) u_slice (
         .a    (a_q[k][k*SLICE +: SLICE]),
         .b    (bp_q[k][k*SLICE +: SLICE]),
         .cin  (c_q[k]),
         .sum  (sum_w[k]),
         .cout (co_w[k])
      );
   end

   assign advance = !v_q[STAGES] || out_ready;

   always_comb begin
      r_last = r_q[STAGES-1];
      r_last[(STAGES-1)*SLICE +: SLICE] = sum_w[STAGES-1];
   end

   always_comb begin
      for (int k = 0; k <= STAGES; k++) begin
         v_d[k] = v_q[k];
         c_d[k] = c_q[k];
         r_d[k] = r_q[k];
      end
      for (int k = 0; k < STAGES; k++) begin
         a_d[k]  = a_q[k];
         bp_d[k] = bp_q[k];
      end
      ovf_d  = ovf_q;
      zero_d = zero_q;
      if (advance) begin
         v_d[0]  = in_valid;
         a_d[0]  = a;
         bp_d[0] = (sel == OP_SUB) ? ~b : b;
         c_d[0]  = (sel == OP_SUB);
         r_d[0]  = '0;
         for (int k = 1; k < STAGES; k++) begin
            a_d[k]  = a_q[k-1];
            bp_d[k] = bp_q[k-1];
         end
         for (int k = 0; k < STAGES; k++) begin
            v_d[k+1] = v_q[k];
            c_d[k+1] = co_w[k];
            r_d[k+1] = r_q[k];
            r_d[k+1][k*SLICE +: SLICE] = sum_w[k];
         end
         zero_d = ~|r_last;
         ovf_d  = (a_q[STAGES-1][WIDTH-1] == bp_q[STAGES-1][WIDTH-1]) &&
                  (r_last[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= STAGES; k++) begin
            v_q[k] <= 1'b0;
            c_q[k] <= 1'b0;
            r_q[k] <= '0;
         end
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]  <= '0;
            bp_q[k] <= '0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         v_q    <= v_d;
         c_q    <= c_d;
         r_q    <= r_d;
         a_q    <= a_d;
         bp_q   <= bp_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign in_ready  = advance;
   assign out_valid = v_q[STAGES];
   assign result    = r_q[STAGES];
   assign c_out     = c_q[STAGES];
   assign ovf       = ovf_q;
   assign zero      = zero_q;
endmodule

// File: tb/tb_clas_pipe.sv
// Directed and scoreboarded checks of clas_pipe at WIDTH=32, SLICE=8.
module tb_clas_pipe;
   import clas_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        sel = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        c_out;
   logic        ovf;
   logic        zero;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_out = 0;
   int          last_cyc = 0;
   bit          gap_en = 1'b0;
   bit          have_last = 1'b0;
   logic [34:0] exp_q [$];

   clas_pipe #(.WIDTH(32), .SLICE(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .c_out     (c_out),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: full-width add, packed as {ovf, zero, c_out, result}.
   function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
      logic [31:0] yb;
      logic [32:0] sm;
      logic        v;
      yb = s ? ~y : y;
      sm = {1'b0, x} + {1'b0, yb} + {32'd0, s};
      v  = (x[31] == yb[31]) && (sm[31] != x[31]);
      return {v, (sm[31:0] == 32'd0), sm[32], sm[31:0]};
   endfunction

   always @(negedge clk) begin : mon
      logic [34:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", {29'd0, ovf, zero, c_out, result}, {29'd0, e});
         end
         if (gap_en && have_last) check("b2b_gap", 64'(cyc - last_cyc), 64'd1);
         have_last = 1'b1;
         last_cyc  = cyc;
         n_out++;
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
      int   guard = 0;
      logic acc = 1'b0;
      a = x;
      b = y;
      sel = s;
      in_valid = 1'b1;
      while (!acc && guard < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) check("send_timeout", 64'd0, 64'd1);
      else exp_q.push_back(model(x, y, s));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic op_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic [31:0] er, input logic ec,
                           input logic eo, input logic ez);
      int n = 0;
      drain();
      send(x, y, s);
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'd4);
      check({tag, "_res"}, {32'd0, result}, {32'd0, er});
      check({tag, "_cout"}, {63'd0, c_out}, {63'd0, ec});
      check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
      check({tag, "_zero"}, {63'd0, zero}, {63'd0, ez});
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] held;
      int          bad;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_result", {32'd0, result}, 64'd0);
      check("rst_cout", {63'd0, c_out}, 64'd0);
      check("rst_ovf", {63'd0, ovf}, 64'd0);
      check("rst_zero", {63'd0, zero}, 64'd0);
      rst = 1'b0;
      check("rdy_after_rst", {63'd0, in_ready}, 64'd1);

      op_check("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      op_check("sub_5_7",  32'd5, 32'd7, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      op_check("sub_7_5",  32'd7, 32'd5, OP_SUB, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
      op_check("add_ovf",  32'h7FFF_FFFF, 32'd1, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      op_check("sub_ovf",  32'h8000_0000, 32'd1, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

      // Ten back-to-back random operations, results must arrive on consecutive cycles.
      drain();
      n_out = 0;
      have_last = 1'b0;
      gap_en = 1'b1;
      for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
      drain();
      gap_en = 1'b0;
      check("b2b_count", 64'(n_out), 64'd10);

      // Output stalled for 6 cycles after the first result of a 6-op burst.
      n_out = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'(i % 2));
         end
         begin
            int n = 0;
            while (!out_valid && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            check("stall_first_vld", {63'd0, out_valid}, 64'd1);
            out_ready = 1'b0;
            held = result;
            for (int i = 0; i < 6; i++) begin
               @(posedge clk);
               #1;
               check("stall_in_ready", {63'd0, in_ready}, 64'd0);
               check("stall_hold", {32'd0, result}, {32'd0, held});
               check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_count", 64'(n_out), 64'd6);

      // Reset with three operations in flight.
      send(32'd10, 32'd20, OP_ADD);
      send(32'd30, 32'd40, OP_ADD);
      send(32'd50, 32'd60, OP_SUB);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("rst_mid_vld", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bad = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid) bad++;
      end
      check("rst_no_stale", 64'(bad), 64'd0);
      op_check("post_rst", 32'h0000_1234, 32'h0000_1111, OP_SUB, 32'h0000_0123, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/clas_pipe.md
CLAS_PIPE -- requirements
Module: clas_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand and result width in bits; legal values are multiples of SLICE, at least SLICE.
REQ-002 The module SHALL have parameter SLICE, default 8, meaning bits per carry-lookahead stage; STAGES = WIDTH/SLICE.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: operands a, b and sel are valid this cycle.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the pipeline accepts an operation this cycle.
REQ-007 The module SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-008 The module SHALL have port sel, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the result fields are valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The module SHALL have port result, output, WIDTH bits: the sum or difference modulo 2^WIDTH.
REQ-012 The module SHALL have port c_out, output, 1 bit: carry out of the MSB; for subtract this is the carry of a+~b+1, so 1 means a>=b unsigned.
REQ-013 The module SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-014 The module SHALL have port zero, output, 1 bit: result equals 0.

Function
REQ-015 An operation SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-016 Subtract SHALL be performed as a + ~b with carry-in 1; add SHALL use carry-in 0.
REQ-017 Stage k (0..STAGES-1) SHALL compute bits [k*SLICE +: SLICE] in one cycle, using the carry registered by stage k-1 (or the carry-in for k=0).
REQ-018 Operand bits above the current stage SHALL be carried through skew registers; completed lower result bits SHALL be carried through deskew registers.
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with no backpressure.
REQ-020 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-021 Stall rule: advance = !out_valid || out_ready, and in_ready = advance.
REQ-022 While advance is 0, every stage register and every output SHALL hold its value.
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid=0 while advancing) SHALL propagate as valid=0.
REQ-024 ovf SHALL equal (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]), where b' = b for add and ~b for subtract; zero SHALL be the NOR of all result bits.
REQ-025 A result SHALL be registered only once, and all output fields SHALL be stable while out_valid && !out_ready.
REQ-026 The all-ones operands with carry-in SHALL ripple a carry through every stage with no special case.

Reset
REQ-027 While rst=1, all stage valid bits and out_valid SHALL be 0, and result, c_out, ovf and zero SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations; no stale result SHALL appear after release.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-030 Package clas_pkg SHALL hold OP_ADD=1'b0, OP_SUB=1'b1 and the default WIDTH/SLICE constants.
REQ-031 Sub-module cla_slice SHALL be a combinational SLICE-bit carry-lookahead adder (generate/propagate, group carry), instantiated once per stage.
REQ-032 Parameter legality (WIDTH % SLICE == 0) SHALL be checked at elaboration.

Verification (WIDTH=32, SLICE=8)
REQ-033 Add 0xFFFFFFFF + 0x00000001 SHALL give, after 4 cycles, result=0, c_out=1, zero=1, ovf=0.
REQ-034 Sub 5 - 7 SHALL give result=0xFFFFFFFE, c_out=0, ovf=0; sub 7 - 5 SHALL give result=2, c_out=1.
REQ-035 Add 0x7FFFFFFF + 1 SHALL give ovf=1; sub 0x80000000 - 1 SHALL give result=0x7FFFFFFF and ovf=1.
REQ-036 Ten back-to-back random ops with out_ready=1 SHALL produce ten results on consecutive cycles, in order, each matching a reference model.
REQ-037 With out_ready=0 for 6 cycles after the first result, in_ready SHALL drop, the output SHALL hold, and no operation SHALL be lost or duplicated.
REQ-038 rst pulsed with 3 ops in flight SHALL keep out_valid at 0 until a new op is accepted after release.
